// File: rtl/uart_dbg_pkg.sv
// Shared types, character constants and parameter helpers for the UART debug reporter.
package uart_dbg_pkg;

    localparam logic [7:0] AsciiCr = 8'h0D;
    localparam logic [7:0] AsciiLf = 8'h0A;

    // Report sequencer: walks the character index and hands bytes to the serialiser.
    typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} rpt_state_e;

    // Byte serialiser bit-level states.
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

    function automatic int unsigned calc_msg_len(input int unsigned num_ch);
        return 5 + 11 * num_ch;
    endfunction

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/uart_debug_report_tx_byte.sv
// 8N1/8N2 byte serialiser: accepts a byte when idle, owns the frame-local baud counter.
module uart_tx_byte
    import uart_dbg_pkg::*;
#(
    parameter int unsigned ClksPerBit = 10,
    parameter int unsigned StopBits   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       done_o,
    output logic       tx_o
);

    localparam int unsigned    CntW     = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(ClksPerBit - 1);
    localparam logic [2:0]     LastStop = 3'(StopBits - 1);

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            bit_end;

    assign bit_end = (baud_q == CntMax);
    assign tx_o    = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_o  = 1'b0;
        ready_o = (state_q == TxIdle);

        if (state_q != TxIdle) begin
            baud_d = bit_end ? '0 : baud_q + CntW'(1);
        end

        case (state_q)
            TxIdle: begin
                if (valid_i) begin
                    state_d = TxStart;
                    baud_d  = '0;
                    shift_d = data_i;
                    tx_d    = 1'b0;
                end
            end
            TxStart: begin
                if (bit_end) begin
                    state_d = TxData;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            TxData: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = TxStop;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            TxStop: begin
                if (bit_end) begin
                    if (bit_q == LastStop) begin
                        state_d = TxIdle;
                        done_o  = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = TxIdle;
        endcase
    end

    // Line must go idle-high the instant reset asserts, even mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TxIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/uart_debug_report_tx.sv
// Multi-channel UART debug reporter: snapshots link status and NUM_CH words, then sends
// one ASCII line per request (periodic timer or force_report).
module uart_debug_report_tx
    import uart_dbg_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 250_000_000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned REPORT_MS = 500,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  force_report,
    input  logic                  link_up,
    input  logic [32*NUM_CH-1:0]  ch_val,
    output logic                  uart_tx,
    output logic                  busy,
    output logic [15:0]           report_cnt,
    output logic [7:0]            drop_cnt
);

    localparam int unsigned ClksPerBit   = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned MsgLen       = calc_msg_len(NUM_CH);
    localparam int unsigned ReportCycles = (CLK_FREQ / 1000) * REPORT_MS;
    localparam int unsigned TimerW       = (ReportCycles > 1) ? $clog2(ReportCycles) : 1;
    localparam int unsigned IdxW         = $clog2(MsgLen);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(ReportCycles - 1);
    localparam logic [IdxW-1:0]   IdxLast   = IdxW'(MsgLen - 1);

    rpt_state_e           state_q, state_d;
    logic [TimerW-1:0]    timer_q, timer_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 pending_q, pending_d;
    logic [15:0]          report_q, report_d;
    logic [7:0]           drop_q, drop_d;
    logic                 snap_link_q, snap_link_d;
    logic [32*NUM_CH-1:0] snap_ch_q, snap_ch_d;

    logic       tick, req;
    logic       byte_valid, byte_ready, byte_done;
    logic [7:0] char;

    assign tick    = enable && (timer_q == TimerLast);
    assign req     = tick || force_report;
    assign timer_d = (!enable || tick) ? '0 : timer_q + TimerW'(1);

    // Character at idx_q, drawn only from the snapshot so live inputs cannot leak in.
    always_comb begin
        char = AsciiLf;
        if (idx_q == IdxW'(0)) begin
            char = 8'h4C;
        end else if (idx_q == IdxW'(1)) begin
            char = 8'h3D;
        end else if (idx_q == IdxW'(2)) begin
            char = {7'h18, snap_link_q};
        end else if (idx_q == IdxW'(MsgLen - 2)) begin
            char = AsciiCr;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx_q == IdxW'(3 + 11 * k)) char = 8'h20;
            if (idx_q == IdxW'(4 + 11 * k)) char = 8'(48 + k);
            if (idx_q == IdxW'(5 + 11 * k)) char = 8'h3D;
            for (int d = 0; d < 8; d++) begin
                if (idx_q == IdxW'(6 + 11 * k + d)) begin
                    char = hex_to_ascii(snap_ch_q[32 * k + 4 * (7 - d) +: 4]);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        report_d    = report_q;
        drop_d      = drop_q;
        snap_link_d = snap_link_q;
        snap_ch_d   = snap_ch_q;
        byte_valid  = 1'b0;

        if (state_q != StIdle && req) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (req || pending_q) begin
                    snap_link_d = link_up;
                    snap_ch_d   = ch_val;
                    idx_d       = '0;
                    state_d     = StLoad;
                    // A request landing on the pending-start cycle re-arms the flag.
                    pending_d   = pending_q && req;
                end
            end
            StLoad: begin
                byte_valid = 1'b1;
                if (byte_ready) state_d = StSend;
            end
            StSend: begin
                if (byte_done) begin
                    if (idx_q == IdxLast) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StLoad;
                    end
                end
            end
            StDone: begin
                report_d = report_q + 16'd1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            report_q    <= '0;
            drop_q      <= '0;
            snap_link_q <= 1'b0;
            snap_ch_q   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            report_q    <= report_d;
            drop_q      <= drop_d;
            snap_link_q <= snap_link_d;
            snap_ch_q   <= snap_ch_d;
        end
    end

    uart_tx_byte #(
        .ClksPerBit(ClksPerBit),
        .StopBits  (STOP_BITS)
    ) u_tx_byte (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid_i(byte_valid),
        .data_i (char),
        .ready_o(byte_ready),
        .done_o (byte_done),
        .tx_o   (uart_tx)
    );

    // Held high across the idle cycle that launches a pending report.
    assign busy       = (state_q != StIdle) || pending_q;
    assign report_cnt = report_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_uart_debug_report_tx.sv
// Scoreboard bench: expected characters are queued at stimulus time; per-DUT monitors
// sample the serial line every cycle and compare the full bit waveform of each frame.
module tb_uart_debug_report_tx;

    localparam int Cpb = 10;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
        logic       pend;
        logic       which;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable, force_report, link_up, enable2, force2;
    logic [63:0] ch_val;
    logic        uart_tx, busy, uart_tx2, busy2;
    logic [15:0] report_cnt, report_cnt2;
    logic [7:0]  drop_cnt, drop_cnt2;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   line_start = 0;
    int   line_span = 0;
    logic mon_en = 1'b1;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_debug_report_tx #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .NUM_CH(2), .REPORT_MS(10), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .force_report(force_report),
        .link_up(link_up), .ch_val(ch_val), .uart_tx(uart_tx), .busy(busy),
        .report_cnt(report_cnt), .drop_cnt(drop_cnt)
    );

    uart_debug_report_tx #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .NUM_CH(2), .REPORT_MS(10), .STOP_BITS(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable2), .force_report(force2),
        .link_up(link_up), .ch_val(ch_val), .uart_tx(uart_tx2), .busy(busy2),
        .report_cnt(report_cnt2), .drop_cnt(drop_cnt2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic push_char(input logic [7:0] c, input logic first, input logic last,
                             input logic pend, input logic w);
        exp_t e;
        e.data  = c;
        e.first = first;
        e.last  = last;
        e.pend  = pend;
        e.which = w;
        exp_q.push_back(e);
    endtask

    // Text is the hand-written line body; CR LF are appended here.
    task automatic push_line(input logic w, input string text, input logic pend);
        for (int i = 0; i < text.len(); i++) begin
            push_char(text[i], i == 0, 1'b0, pend && (i == 0), w);
        end
        push_char(8'h0D, 1'b0, 1'b0, 1'b0, w);
        push_char(8'h0A, 1'b0, 1'b1, 1'b0, w);
    endtask

    function automatic logic txs(input logic w);
        return w ? uart_tx2 : uart_tx;
    endfunction

    task automatic monitor(input logic w);
        exp_t       e;
        logic       lvl, ex, ok;
        logic [7:0] got;
        int         s, bi, nbits, prev_end;
        prev_end = 0;
        nbits    = w ? 11 : 10;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && txs(w) == 1'b0) begin
                s   = cyc;
                ok  = 1'b1;
                got = '0;
                if (exp_q.size() == 0) begin
                    e  = '0;
                    ok = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                end
                for (int j = 0; j < nbits * Cpb; j++) begin
                    if (j > 0) @(negedge clk);
                    lvl = txs(w);
                    bi  = j / Cpb;
                    if (bi == 0) ex = 1'b0;
                    else if (bi <= 8) ex = e.data[bi - 1];
                    else ex = 1'b1;
                    if (lvl !== ex) ok = 1'b0;
                    if (bi >= 1 && bi <= 8 && (j % Cpb) == Cpb / 2) got[bi - 1] = lvl;
                end
                checks++;
                if (!ok || e.which != w) begin
                    fails++;
                    $display("FAIL frame dut%0d: got char=%02h expected char=%02h waveform_ok=%0d",
                             w, got, e.data, ok);
                end
                if (e.first) begin
                    line_start = s;
                    if (e.pend) begin
                        checks++;
                        if (s - prev_end != 4) begin
                            fails++;
                            $display("FAIL pending_gap: got=%0d expected=4", s - prev_end);
                        end
                    end
                end else begin
                    checks++;
                    if (s - prev_end != 2) begin
                        fails++;
                        $display("FAIL char_gap dut%0d: got=%0d expected=2", w, s - prev_end);
                    end
                end
                prev_end = cyc;
                if (e.last) line_span = prev_end - line_start + 2;
            end
        end
    endtask

    initial monitor(1'b0);
    initial monitor(1'b1);

    task automatic pulse();
        force_report = 1'b1;
        @(posedge clk);
        #1 force_report = 1'b0;
    endtask

    task automatic wait_idle(input logic w, input int budget, input string name);
        int n = 0;
        while ((w ? busy2 : busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(w ? busy2 : busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, a, b, bad, n;
        enable = 1'b1; force_report = 1'b0; link_up = 1'b0; ch_val = '0;
        enable2 = 1'b0; force2 = 1'b0;

        // Reset values, then periodic first report after one full timer period.
        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_tx", 32'(uart_tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_report_cnt", 32'(report_cnt), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        push_line(1'b0, "L=0 0=00000000 1=00000000", 1'b0);
        rst_n = 1'b1;
        r = cyc;
        bad = 0;
        repeat (9999) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0 || report_cnt !== 16'd0 || drop_cnt !== 8'd0)
                bad++;
        end
        check("idle_quiet", 32'(bad), 0);
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("busy_rise_cycle", 32'(cyc - r), 10000);
        repeat (100) @(posedge clk);
        #1 enable = 1'b0;
        wait_idle(1'b0, 4000, "line1_done");
        check("periodic_start_cycle", 32'(line_start - r), 10001);
        check("report_cnt_1", 32'(report_cnt), 1);

        // Forced report; inputs change mid-line and must not leak in.
        @(posedge clk);
        #1;
        link_up = 1'b1;
        ch_val = {32'hDEADBEEF, 32'h000000A5};
        push_line(1'b0, "L=1 0=000000A5 1=DEADBEEF", 1'b0);
        a = cyc;
        pulse();
        check("busy_after_req", 32'(busy), 1);
        repeat (50) @(posedge clk);
        #1;
        link_up = 1'b0;
        ch_val = {32'h12345678, 32'h9ABCDEF0};
        wait_idle(1'b0, 4000, "line2_done");
        check("start_latency", 32'(line_start - a), 2);
        check("line_span_1stop", 32'(line_span), 27 * 101);
        check("report_cnt_2", 32'(report_cnt), 2);
        check("queue_empty_2", 32'(exp_q.size()), 0);

        // Three requests in one report: one pending, one dropped.
        @(posedge clk);
        #1;
        link_up = 1'b1;
        ch_val = {32'hCAFEF00D, 32'h00C0FFEE};
        push_line(1'b0, "L=1 0=00C0FFEE 1=CAFEF00D", 1'b0);
        push_line(1'b0, "L=0 0=76543210 1=0BADF00D", 1'b1);
        pulse();
        repeat (200) @(posedge clk);
        #1;
        link_up = 1'b0;
        ch_val = {32'h0BADF00D, 32'h76543210};
        pulse();
        check("drop_cnt_after_pend", 32'(drop_cnt), 0);
        repeat (300) @(posedge clk);
        #1 pulse();
        check("drop_cnt_after_3rd", 32'(drop_cnt), 1);
        wait_idle(1'b0, 8000, "line34_done");
        check("report_cnt_4", 32'(report_cnt), 4);
        check("drop_cnt_final", 32'(drop_cnt), 1);
        check("queue_empty_3", 32'(exp_q.size()), 0);

        // Two stop bits on the second instance.
        @(posedge clk);
        #1;
        link_up = 1'b1;
        ch_val = {32'hA5A55A5A, 32'h13579BDF};
        push_line(1'b1, "L=1 0=13579BDF 1=A5A55A5A", 1'b0);
        b = cyc;
        force2 = 1'b1;
        @(posedge clk);
        #1 force2 = 1'b0;
        wait_idle(1'b1, 5000, "line_2stop_done");
        check("start_latency_2stop", 32'(line_start - b), 2);
        check("line_span_2stop", 32'(line_span), 27 * 111);
        check("report_cnt2", 32'(report_cnt2), 1);
        check("queue_empty_4", 32'(exp_q.size()), 0);

        // Asynchronous reset in the middle of a data bit.
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        a = cyc;
        pulse();
        repeat (14) @(posedge clk);
        #2;
        check("tx_low_in_data", 32'(uart_tx), 0);
        rst_n = 1'b0;
        #1;
        check("rst_async_tx", 32'(uart_tx), 1);
        check("rst_async_busy", 32'(busy), 0);
        check("rst_async_report_cnt", 32'(report_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("no_partial_resume", 32'(bad), 0);
        check("drop_after_rst", 32'(drop_cnt), 0);
        check("queue_empty_final", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_debug_report_tx.md
# uart_debug_report_tx

Multi-channel, parametrised UART debug reporter that replaces the single-counter debug transmitter. It snapshots a link-status bit and NUM_CH 32-bit status words, then serialises them as one ASCII line. Reports are sent periodically or on demand. It sits on the XDMA axi_aclk domain and drives the board UART TX pin directly.

## Interface
Parameters:
- CLK_FREQ, 250_000_000: clock frequency in Hz.
- BAUD_RATE, 115200: line rate; CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE (rounded).
- NUM_CH, 4: number of 32-bit channels, legal range 1..8.
- REPORT_MS, 500: periodic report interval in ms; REPORT_CYCLES = (CLK_FREQ/1000)*REPORT_MS.
- STOP_BITS, 1: 1 or 2 stop bits.

Ports:
- clk  in  1  XDMA axi_aclk; single clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  periodic-report enable.
- force_report  in  1  single-cycle request for an immediate report.
- link_up  in  1  link status, sampled at snapshot.
- ch_val  in  32*NUM_CH  channel k occupies bits [32k+31:32k].
- uart_tx  out  1  serial line, idle high.
- busy  out  1  high from snapshot until the last stop bit ends.
- report_cnt  out  16  count of completed reports, wraps.
- drop_cnt  out  8  count of rejected requests, saturates at 255.

## Operation
- Line format: "L=" then link digit ('0'/'1'); then for each k = 0..NUM_CH-1: space, '0'+k, '=', 8 uppercase hex digits (MSB first); then CR (0x0D) and LF (0x0A).
- MSG_LEN = 5 + 11*NUM_CH. Example: NUM_CH=4 gives 49 characters.
- Request sources:
  - Periodic timer: counts while enable=1 and pulses at REPORT_CYCLES-1. It is held at 0 while enable=0.
  - force_report: accepted regardless of enable.
- Request handling:
  - Idle: a request snapshots link_up and ch_val into internal registers in the same cycle. The report starts and busy rises the next cycle.
  - Busy with pending flag clear: a request sets a one-deep pending flag. No snapshot is taken.
  - Busy with pending flag already set: the request increments drop_cnt (saturating).
  - Pending flag set when a report finishes: a fresh snapshot is taken on the first idle cycle, with no gap beyond one cycle.
  - Timer pulse and force_report in the same cycle count as one request.
- Character generation: a combinational function of the character index and the snapshot. Live inputs never affect an in-progress line.
- enable deasserted mid-report: the current report and any pending report still complete.
- FSM states:
  - IDLE: uart_tx=1. On a request → LOAD.
  - LOAD: fetch character[idx], reset the baud counter → START.
  - START: 1 bit time low → DATA.
  - DATA: 8 bits, LSB first → STOP.
  - STOP: STOP_BITS bit times high. If idx == MSG_LEN-1 → DONE, else idx+1 → LOAD.
  - DONE: report_cnt+1. If pending → IDLE path (snapshot), else → IDLE.

## Timing
- Reset values: uart_tx=1, busy=0, report_cnt=0, drop_cnt=0, pending=0, timer=0, state=IDLE. Reset mid-frame forces uart_tx high immediately (asynchronous).
- The baud counter is frame-local. It restarts in LOAD, so every bit is exactly CLKS_PER_BIT cycles. The start-bit edge comes 2 cycles after the request (request cycle, LOAD).
- Consecutive characters are separated by one LOAD cycle; no extra idle bit.
- Line duration: MSG_LEN*((9+STOP_BITS)*CLKS_PER_BIT + 1) cycles.
- report_cnt increments in the DONE cycle. busy falls in the cycle after DONE unless a pending report starts.

## Structure
- Package uart_dbg_pkg:
  - hex_to_ascii function.
  - CLKS_PER_BIT and MSG_LEN computation functions.
  - FSM state enum.
  - CR/LF constants.
- Sub-module uart_tx_byte: byte serialiser with valid/ready, CLKS_PER_BIT and STOP_BITS parameters. It owns the baud counter and bit FSM.
- Top level owns: timer, request arbitration, snapshot registers, character mux, counters.

## Test plan
Parameters: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clks/bit), NUM_CH=2, REPORT_MS=10.
- Reset, then idle: uart_tx=1, busy=0, both counters 0 for 9,999 cycles; the first start edge occurs 10,001 cycles after reset release.
- Single report: ch_val={0xDEADBEEF, 0x0000_00A5}, link_up=1, force_report pulse → line "L=1 0=000000A5 1=DEADBEEF\r\n" decoded (27 chars), each bit exactly 10 cycles; report_cnt=1.
- Inputs changed mid-report → decoded line still matches the snapshot values.
- Three force_report pulses during one report → exactly one follow-up report; drop_cnt=1; report_cnt=2.
- STOP_BITS=2 → stop interval of 20 cycles; line length 27*(110+1) cycles.
- rst_n low mid-DATA → uart_tx=1 in the same cycle; after release, no partial frame resumes.
